dmem_access_unit: RTL
=====================

# dmem_access_unit

MEM-stage data-memory access controller for the 5-stage RV32I pipeline. Takes a load or store from the EX/MEM pipeline register and issues a single word-aligned request to the data cache. For stores it builds the byte-enable mask and lane-shifted write data. For loads it captures the raw word and hands it, with the byte offset and funct3, to the downstream load aligner. It stalls the pipeline for the duration of the cache transaction.

## Interface
Parameters: none.
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  MEM stage holds a valid instruction
- req_read  in  1  instruction is a load
- req_write  in  1  instruction is a store
- req_funct3  in  3  load/store funct3
- req_addr  in  32  effective byte address
- req_wdata  in  32  store source (rs2 value)
- pipe_advance  in  1  pipeline registers load this cycle
- stall  out  1  freeze pipeline
- misaligned  out  1  access not naturally aligned; no memory traffic generated
- load_raw  out  32  captured cache word
- load_alignment  out  2  addr[1:0] of the captured load
- load_funct3  out  3  funct3 of the captured load
- dmem_read  out  1  cache read request
- dmem_write  out  1  cache write request
- dmem_address  out  32  {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-shifted store data
- dmem_byte_enable  out  4  byte write mask; 4'b1111 on reads
- dmem_resp  in  1  cache completes the request (one-cycle pulse)
- dmem_rdata  in  32  read word, valid with dmem_resp

## Operation
- FSM states: IDLE, ACCESS, DONE. On reset, state is IDLE.
- Reset values: all registered outputs are 0. This covers dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable, load_raw, load_alignment and load_funct3.
- The request is a legal access (`go`) when all of the following hold:
  - req_valid is high.
  - req_read or req_write is high.
  - misaligned is low.
  - funct3 is legal: 000/001/010/100/101 for loads, 000/001/010 for stores.
- An illegal funct3 completes with no access and no stall.
- misaligned is combinational and asserted only in IDLE with req_valid high:
  - halfword (funct3[1:0]=01) with addr[0]=1
  - word (010) with addr[1:0]≠00
- IDLE → ACCESS on `go`. The request is registered on this transition:
  - dmem_address = {req_addr[31:2],2'b00}
  - load_alignment = req_addr[1:0]
  - load_funct3 = req_funct3
  - store byte-enable (dmem_byte_enable): sb = 4'b0001<<addr[1:0], sh = 4'b0011<<addr[1:0], sw = 4'b1111
  - dmem_wdata = req_wdata << (8·addr[1:0]), truncated to 32 bits
- In ACCESS, exactly one of dmem_read/dmem_write is high. If req_read and req_write are both high, only the read is performed.
- ACCESS → DONE on dmem_resp. On a read, load_raw ← dmem_rdata at that edge. dmem_read/dmem_write deassert at the same edge.
- DONE → IDLE when pipe_advance is high. DONE blocks reissue while the pipeline is frozen by another hazard.
- stall = (IDLE & go) | ACCESS. stall is low in DONE and for misaligned or illegal requests.
- Request inputs are ignored outside IDLE. dmem_resp is ignored outside ACCESS.
- load_raw, load_alignment and load_funct3 hold until the next load capture.

## Timing
- Issue: `go` sampled at edge N. dmem_read/dmem_write are high from N+1 through the cycle in which dmem_resp is seen.
- Minimum load latency: resp in cycle N+1 gives DONE at N+2, with load_raw valid from N+2. The instruction stalls 2 cycles.
- There is no combinational path from dmem_resp to stall. stall drops one cycle after resp.
- Asynchronous rst mid-ACCESS:
  - Immediately returns to IDLE and clears dmem_read/dmem_write.
  - A pending response arriving later is ignored.
- Back-to-back accesses: DONE→IDLE on pipe_advance. The next `go` is sampled one cycle later, so there is no gap beyond one IDLE cycle.

## Test plan
- Load word: addr=0x0000_1004, lw, resp after 3 cycles with rdata=0xDEADBEEF.
  - dmem_address=0x1004, byte_enable=1111.
  - load_raw=0xDEADBEEF, alignment=00.
  - stall high exactly 4 cycles.
- Store byte: addr=0x2003, sb, wdata=0x0000_00A5 → dmem_write=1, byte_enable=1000, dmem_wdata=0xA500_0000, address=0x2000.
- Store halfword: addr=0x2002, sh, wdata=0x1234 → byte_enable=1100, dmem_wdata=0x1234_0000.
- Misaligned: lw at 0x3001 → misaligned=1, stall=0, no dmem_read for 5 cycles.
- Held in DONE: load completes with pipe_advance=0 for 3 cycles → no second dmem_read; IDLE after pipe_advance=1.
- Reset in ACCESS: rst pulsed 2 cycles after issue → dmem_read=0 asynchronously, all outputs 0; a later dmem_resp does not change load_raw.

Source files
------------

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access controller: issues one word-aligned cache request per
// load/store, builds store lanes/byte enables, captures load words and stalls the pipe.
//
// state  | meaning
// IDLE   | waiting for a legal request from EX/MEM
// ACCESS | request outstanding at the cache, pipeline frozen
// DONE   | access finished, waiting for the pipeline to advance
module dmem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        pipe_advance,
  output logic        stall,
  output logic        misaligned,
  output logic [31:0] load_raw,
  output logic [1:0]  load_alignment,
  output logic [2:0]  load_funct3,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;

  logic       is_half;
  logic       is_word;
  logic       f3_legal;
  logic       go;
  logic [3:0] store_be;

  always_comb begin
    is_half    = (req_funct3[1:0] == 2'b01);
    is_word    = (req_funct3[1:0] == 2'b10);
    misaligned = (state == IDLE) && req_valid &&
                 ((is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00)));
    // unsigned load variants exist only for loads
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = req_read;
      default:                f3_legal = 1'b0;
    endcase
    go    = (state == IDLE) && req_valid && (req_read || req_write) && !misaligned && f3_legal;
    stall = go || (state == ACCESS);
    case (req_funct3[1:0])
      2'b00:   store_be = 4'b0001 << req_addr[1:0];
      2'b01:   store_be = 4'b0011 << req_addr[1:0];
      default: store_be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= '0;
      load_raw         <= '0;
      load_alignment   <= '0;
      load_funct3      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state        <= ACCESS;
            dmem_address <= {req_addr[31:2], 2'b00};
            dmem_wdata   <= req_wdata << {req_addr[1:0], 3'b000};
            if (req_read) begin
              dmem_read        <= 1'b1;
              dmem_write       <= 1'b0;
              dmem_byte_enable <= 4'b1111;
              load_alignment   <= req_addr[1:0];
              load_funct3      <= req_funct3;
            end else begin
              dmem_read        <= 1'b0;
              dmem_write       <= 1'b1;
              dmem_byte_enable <= store_be;
            end
          end
        end
        ACCESS: begin
          if (dmem_resp) begin
            if (dmem_read) load_raw <= dmem_rdata;
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          if (pipe_advance) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
